cpu_bus_rmw: RTL and testbench
==============================

Name: cpu_bus_rmw

Overview:
Parametrised successor to the RISC5 CPU bus interface. It sits between the CPU load/store port and the word-wide system bus, which has no byte enables.
- Byte and halfword loads are served by lane select plus optional sign extension.
- Byte and halfword stores are done as a read-modify-write (RMW): one bus read, then one bus write.
- A bus watchdog terminates hung cycles with an error acknowledge.

Parameters:
ADDR_WIDTH, 24, CPU byte-address width; bus word address is [ADDR_WIDTH-1:2].
TIMEOUT_CYCLES, 255, bus_stb cycles without bus_ack before an error termination; range 1..65535.
TO_WIDTH, 16, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cpu_stb  in  1  CPU request; held until cpu_ack
cpu_we  in  1  1 = store, 0 = load
cpu_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
cpu_sext  in  1  loads only: sign-extend the sub-word result
cpu_addr  in  ADDR_WIDTH  byte address
cpu_dout  in  32  store data, right-aligned
cpu_din  out  32  load data, right-aligned
cpu_ack  out  1  request complete
cpu_err  out  1  qualifies cpu_ack: access failed
bus_stb  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  ADDR_WIDTH-2  word address
bus_dout  out  32  bus write data
bus_din  in  32  bus read data
bus_ack  in  1  bus completion

Behaviour:
- State machine states: IDLE, RMW_RD, RMW_WR, ERR. Registers:
  - state
  - wbuf[31:0] (write buffer)
  - tcnt[TO_WIDTH-1:0] (watchdog counter)
- Reset (async): state=IDLE, wbuf=0, tcnt=0. With cpu_stb low, outputs are all 0: bus_stb, cpu_ack, cpu_err, bus_we, cpu_din, bus_dout.
- Unused data outputs are driven 0, never x.
- bus_addr = cpu_addr[ADDR_WIDTH-1:2] in every state.
- Lane selection:
  - Byte lane = cpu_addr[1:0]: lane 0 is bits 7:0, lane 3 is bits 31:24.
  - Halfword lane = cpu_addr[1]: 0 selects bits 15:0, 1 selects bits 31:16. cpu_addr[0] is ignored.
  - Word accesses ignore cpu_addr[1:0].
- IDLE, load: combinational pass-through with zero added latency.
  - bus_stb=cpu_stb, bus_we=0.
  - cpu_din = selected lane, zero-extended, or sign-extended from the lane MSB if cpu_sext=1. Words are passed unchanged.
  - cpu_ack=bus_ack.
- IDLE, word store: bus_stb=1, bus_we=1, bus_dout=cpu_dout, cpu_ack=bus_ack.
- IDLE, sub-word store: moves to RMW_RD on the same edge the request is seen. No bus strobe in that IDLE cycle, which adds one cycle.
- RMW_RD:
  - bus_stb=1, bus_we=0, cpu_ack=0.
  - On bus_ack: wbuf <= bus_din with the selected lane(s) replaced by cpu_dout[7:0] or [15:0]; go to RMW_WR.
- RMW_WR:
  - bus_stb=1, bus_we=1, bus_dout=wbuf, cpu_ack=bus_ack.
  - On bus_ack, go to IDLE.
- Minimum RMW store latency: 1 + read + write cycles, i.e. 3 cycles with single-cycle-ack slaves.
- Watchdog:
  - tcnt increments each cycle that bus_stb=1 and bus_ack=0.
  - tcnt clears on bus_ack, when bus_stb=0, and on entry to RMW_WR.
  - When tcnt reaches TIMEOUT_CYCLES-1 with no ack, go to ERR on the next edge.
  - ERR lasts one cycle: bus_stb=0, cpu_ack=1, cpu_err=1, cpu_din=0; then IDLE.
  - A bus_ack arriving in the same cycle as the timeout takes priority: normal completion, no error.
- The CPU must drop cpu_stb the cycle after cpu_ack.
  - An IDLE cycle with cpu_stb=0 issues nothing.
  - Back-to-back requests are allowed from the cycle after ack.
- Reset mid-RMW aborts immediately: no write is issued and memory keeps its old word.
- cpu_err=0 whenever cpu_ack is produced by a normal bus_ack.

Optional Feature:
CPU_BUS_MISALIGN_EN:
- Defined: a halfword with cpu_addr[0]=1, or a word with cpu_addr[1:0]≠0, issues no bus cycle. It goes from IDLE to ERR and is answered next cycle with cpu_ack=1, cpu_err=1.
- Undefined: misaligned low address bits are silently ignored as described above, and cpu_err is only raised by the watchdog.

Test Plan:
- Byte load, addr 0x000003, bus_din=0x80A1B2C3, cpu_sext=1 -> cpu_din=0xFFFFFF80 in the bus_ack cycle. With cpu_sext=0 -> 0x00000080.
- Halfword store, addr 0x000012, cpu_dout=0x0000BEEF, memory word 0x11223344 -> read then write of 0xBEEF3344 to bus_addr 0x000004. cpu_ack on the 3rd cycle with zero-wait slave.
- Byte store, lane 1, cpu_dout=0x5A, memory 0xFFFFFFFF, slave with 2 wait states per access -> write data 0xFFFF5AFF. cpu_ack exactly once, cpu_err=0.
- Word load to non-responding slave, TIMEOUT_CYCLES=4 -> bus_stb high 4 cycles, then one cycle cpu_ack=1, cpu_err=1, bus_stb=0.
- Assert rst while in RMW_WR before bus_ack -> bus_stb=0 immediately, state IDLE, memory word unchanged.
- With CPU_BUS_MISALIGN_EN defined: word load at 0x000006 -> no bus_stb, cpu_ack=1, cpu_err=1 the cycle after the request.

Source files
------------

// File: rtl/cpu_bus_rmw.sv
// cpu_bus_rmw: CPU load/store to word-bus bridge with sub-word RMW stores and bus watchdog; define CPU_BUS_MISALIGN_EN to fault misaligned halfword/word accesses
module cpu_bus_rmw #(
  parameter int ADDR_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_stb,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_sext,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_dout,
  output logic [31:0]           cpu_din,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic                  bus_stb,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-3:0] bus_addr,
  output logic [31:0]           bus_dout,
  input  logic [31:0]           bus_din,
  input  logic                  bus_ack
);
  typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR, ERR} state_t;
  state_t state, state_nxt;
  logic [31:0] wbuf, merged, ld;
  logic [TO_WIDTH-1:0] tcnt;
  logic [7:0] bsel;
  logic [15:0] hsel;
  logic is_byte, is_half, is_sub, mis, to_hit;
  assign bus_addr = cpu_addr[ADDR_WIDTH-1:2];
  assign is_byte = cpu_size == 2'b00;
  assign is_half = cpu_size == 2'b01;
  assign is_sub = ~cpu_size[1];
  assign to_hit = ~bus_ack & (tcnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));
`ifdef CPU_BUS_MISALIGN_EN
  assign mis = is_half ? cpu_addr[0] : (cpu_size[1] & |cpu_addr[1:0]);
`else
  assign mis = 1'b0;
`endif
  // load lane select with optional sign extension, and store lane merge into the read word
  always_comb begin
    bsel = cpu_addr[1] ? (cpu_addr[0] ? bus_din[31:24] : bus_din[23:16])
                       : (cpu_addr[0] ? bus_din[15:8] : bus_din[7:0]);
    hsel = cpu_addr[1] ? bus_din[31:16] : bus_din[15:0];
    ld = is_byte ? {{24{cpu_sext & bsel[7]}}, bsel}
       : is_half ? {{16{cpu_sext & hsel[15]}}, hsel} : bus_din;
    merged = is_half ? (cpu_addr[1] ? {cpu_dout[15:0], bus_din[15:0]} : {bus_din[31:16], cpu_dout[15:0]})
           : cpu_addr[1:0] == 2'd0 ? {bus_din[31:8], cpu_dout[7:0]}
           : cpu_addr[1:0] == 2'd1 ? {bus_din[31:16], cpu_dout[7:0], bus_din[7:0]}
           : cpu_addr[1:0] == 2'd2 ? {bus_din[31:24], cpu_dout[7:0], bus_din[15:0]}
           : {cpu_dout[7:0], bus_din[23:0]};
  end
  // next state and bus/CPU handshake outputs
  always_comb begin
    state_nxt = state;
    bus_stb = 1'b0;
    bus_we = 1'b0;
    bus_dout = '0;
    cpu_din = '0;
    cpu_ack = 1'b0;
    cpu_err = 1'b0;
    case (state)
      IDLE: if (cpu_stb) begin
        if (mis) state_nxt = ERR;
        else if (cpu_we && is_sub) state_nxt = RMW_RD;
        else begin
          bus_stb = 1'b1;
          bus_we = cpu_we;
          bus_dout = cpu_we ? cpu_dout : '0;
          cpu_din = cpu_we ? '0 : ld;
          cpu_ack = bus_ack;
          state_nxt = to_hit ? ERR : IDLE;
        end
      end
      RMW_RD: begin
        bus_stb = 1'b1;
        state_nxt = bus_ack ? RMW_WR : to_hit ? ERR : RMW_RD;
      end
      RMW_WR: begin
        bus_stb = 1'b1;
        bus_we = 1'b1;
        bus_dout = wbuf;
        cpu_ack = bus_ack;
        state_nxt = bus_ack ? IDLE : to_hit ? ERR : RMW_WR;
      end
      default: begin
        cpu_ack = 1'b1;
        cpu_err = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end
  // state, write buffer capture on the RMW read, and watchdog count of unacknowledged strobe cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wbuf <= '0;
      tcnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RMW_RD && bus_ack) wbuf <= merged;
      tcnt <= (bus_stb && !bus_ack && state_nxt != ERR) ? tcnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_cpu_bus_rmw.sv
// tb_cpu_bus_rmw: directed checks of cpu_bus_rmw against a word memory slave with programmable wait states
module tb_cpu_bus_rmw;
  logic clk = 0, rst = 1;
  logic cpu_stb = 0, cpu_we = 0, cpu_sext = 0;
  logic [1:0] cpu_size = 0;
  logic [23:0] cpu_addr = 0;
  logic [31:0] cpu_dout = 0, cpu_din, bus_dout, bus_din;
  logic cpu_ack, cpu_err, bus_stb, bus_we, bus_ack;
  logic [21:0] bus_addr;
  logic [31:0] mem [16];
  int waits = 0, wcnt = 0;
  logic hang = 0;
  int checks = 0, errors = 0;
  int cyc, stbs;
  logic [31:0] wdata, got_din;
  logic got_err, done, ack_stb, post_ack;

  cpu_bus_rmw #(.ADDR_WIDTH(24), .TIMEOUT_CYCLES(4), .TO_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_sext(cpu_sext), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .bus_stb(bus_stb), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  assign bus_din = mem[bus_addr[3:0]];
  assign bus_ack = bus_stb && !hang && wcnt == waits;

  always @(posedge clk) begin
    wcnt <= (!bus_stb || bus_ack) ? 0 : wcnt + 1;
    if (bus_stb && bus_we && bus_ack) mem[bus_addr[3:0]] <= bus_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic sx, input logic [23:0] a, input logic [31:0] d);
    cpu_we = we; cpu_size = sz; cpu_sext = sx; cpu_addr = a; cpu_dout = d; cpu_stb = 1;
    cyc = 0; stbs = 0; wdata = 0; got_din = 0; got_err = 0; done = 0; ack_stb = 0;
    while (!done && cyc < 50) begin
      #1;
      cyc++;
      if (bus_stb) stbs++;
      if (bus_stb && bus_we && bus_ack) wdata = bus_dout;
      if (cpu_ack) begin
        done = 1; got_din = cpu_din; got_err = cpu_err; ack_stb = bus_stb;
      end
      tick;
    end
    cpu_stb = 0;
    #1;
    post_ack = cpu_ack;
    chk("ack_within_bound", {31'd0, done}, 32'd1);
    tick;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h80A1B2C3;
    mem[1] = 32'h01234567;
    mem[4] = 32'h11223344;
    mem[8] = 32'hFFFFFFFF;
    mem[7] = 32'h76543210;
    mem[12] = 32'hCAFEF00D;
    #2;
    chk("rst_bus_stb", {31'd0, bus_stb}, 0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("rst_cpu_err", {31'd0, cpu_err}, 0);
    chk("rst_bus_we", {31'd0, bus_we}, 0);
    chk("rst_cpu_din", cpu_din, 0);
    chk("rst_bus_dout", bus_dout, 0);
    tick;
    rst = 0;
    tick;
    chk("idle_no_stb", {31'd0, bus_stb}, 0);

    xfer(0, 2'b00, 1, 24'h000003, 0);
    chk("lb3_sext", got_din, 32'hFFFFFF80);
    chk("lb3_lat", cyc, 1);
    chk("lb3_err", {31'd0, got_err}, 0);
    xfer(0, 2'b00, 0, 24'h000003, 0);
    chk("lb3_zext", got_din, 32'h00000080);
    xfer(0, 2'b00, 1, 24'h000000, 0);
    chk("lb0_sext", got_din, 32'hFFFFFFC3);
    xfer(0, 2'b00, 0, 24'h000001, 0);
    chk("lb1_zext", got_din, 32'h000000B2);
    xfer(0, 2'b01, 1, 24'h000002, 0);
    chk("lh2_sext", got_din, 32'hFFFF80A1);
    xfer(0, 2'b01, 0, 24'h000000, 0);
    chk("lh0_zext", got_din, 32'h0000B2C3);
    xfer(0, 2'b11, 1, 24'h000000, 0);
    chk("lw_size3", got_din, 32'h80A1B2C3);

    xfer(1, 2'b01, 0, 24'h000012, 32'h0000BEEF);
    chk("sh_wdata", wdata, 32'hBEEF3344);
    chk("sh_lat", cyc, 3);
    chk("sh_mem", mem[4], 32'hBEEF3344);
    chk("sh_stbs", stbs, 2);

    waits = 2;
    xfer(1, 2'b00, 0, 24'h000021, 32'h0000005A);
    chk("sb_wdata", wdata, 32'hFFFF5AFF);
    chk("sb_lat", cyc, 7);
    chk("sb_err", {31'd0, got_err}, 0);
    chk("sb_ack_once", {31'd0, post_ack}, 0);
    chk("sb_mem", mem[8], 32'hFFFF5AFF);

    waits = 0;
    xfer(1, 2'b10, 0, 24'h000014, 32'hA5A55A5A);
    chk("sw_wdata", wdata, 32'hA5A55A5A);
    chk("sw_lat", cyc, 1);
    chk("sw_mem", mem[5], 32'hA5A55A5A);

    hang = 1;
    xfer(0, 2'b10, 0, 24'h000018, 0);
    chk("to_stbs", stbs, 4);
    chk("to_lat", cyc, 5);
    chk("to_err", {31'd0, got_err}, 1);
    chk("to_ack_stb", {31'd0, ack_stb}, 0);
    chk("to_din", got_din, 0);
    hang = 0;

    waits = 3;
    xfer(0, 2'b10, 0, 24'h00001C, 0);
    chk("ack_at_to_err", {31'd0, got_err}, 0);
    chk("ack_at_to_din", got_din, 32'h76543210);
    chk("ack_at_to_lat", cyc, 4);

    waits = 2;
    cpu_we = 1; cpu_size = 2'b00; cpu_sext = 0; cpu_addr = 24'h000030; cpu_dout = 32'h11; cpu_stb = 1;
    for (int i = 0; i < 4; i++) tick;
    chk("rst_mid_in_wr", {30'd0, bus_stb, bus_we}, 32'd3);
    chk("rst_mid_no_ack", {31'd0, cpu_ack}, 0);
    rst = 1;
    #1;
    chk("rst_mid_stb", {31'd0, bus_stb}, 0);
    cpu_stb = 0;
    tick;
    tick;
    rst = 0;
    tick;
    tick;
    chk("rst_mid_mem", mem[12], 32'hCAFEF00D);
    waits = 0;

    xfer(0, 2'b10, 0, 24'h000006, 0);
`ifdef CPU_BUS_MISALIGN_EN
    chk("mis_stbs", stbs, 0);
    chk("mis_lat", cyc, 2);
    chk("mis_err", {31'd0, got_err}, 1);
`else
    chk("mis_ign_din", got_din, 32'h01234567);
    chk("mis_ign_lat", cyc, 1);
    chk("mis_ign_err", {31'd0, got_err}, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
